multdiv_ctrl: RTL and testbench

//  Sequences the shared multi-cycle mult/div unit for the X stage. Fires on control_mult/control_div from the decoder.

---
 rtl/multdiv_pkg.sv | 25 ++
 rtl/multdiv_ctrl_if.sv | 46 ++++
 rtl/md_watchdog.sv | 33 +++
 rtl/multdiv_ctrl.sv | 120 ++++++++++++
 tb/tb_multdiv_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the mult/div sequencer.
package multdiv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } md_state_e;

   typedef enum logic {
      OP_MULT,
      OP_DIV
   } md_op_e;

   localparam int unsigned RSTATUS_REG = 30;

   localparam logic [2:0] MD_ERR_MULT    = 3'd4;
   localparam logic [2:0] MD_ERR_DIV     = 3'd5;
   localparam logic [2:0] MD_ERR_TIMEOUT = 3'd6;

   function automatic logic [2:0] err_code(md_op_e op);
      return (op == OP_DIV) ? MD_ERR_DIV : MD_ERR_MULT;
   endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Issue, unit and write-back signals of the mult/div sequencer.
// Perf counter signals exist only with MULTDIV_PERF_EN.
interface multdiv_ctrl_if #(
   parameter int REG_W = 5
`ifdef MULTDIV_PERF_EN
   , parameter int CNT_W = 32
`endif
);
   logic             issue_mult;
   logic             issue_div;
   logic [REG_W-1:0] issue_rd;
   logic             md_ready;
   logic             md_exception;
   logic             md_start_mult;
   logic             md_start_div;
   logic             stall;
   logic             wb_valid;
   logic [REG_W-1:0] wb_rd;
   logic             wb_sel_status;
   logic [2:0]       wb_code;
`ifdef MULTDIV_PERF_EN
   logic [CNT_W-1:0] perf_ops;
   logic [CNT_W-1:0] perf_busy;
`endif

   modport master (
      output issue_mult, issue_div, issue_rd,
      output md_ready, md_exception,
      input  md_start_mult, md_start_div, stall,
      input  wb_valid, wb_rd, wb_sel_status, wb_code
`ifdef MULTDIV_PERF_EN
      , input perf_ops, perf_busy
`endif
   );

   modport slave (
      input  issue_mult, issue_div, issue_rd,
      input  md_ready, md_exception,
      output md_start_mult, md_start_div, stall,
      output wb_valid, wb_rd, wb_sel_status, wb_code
`ifdef MULTDIV_PERF_EN
      , output perf_ops, perf_busy
`endif
   );

endinterface

// File: rtl/md_watchdog.sv
// Busy-cycle watchdog: counts while enabled, flags the last allowed cycle.
module md_watchdog #(
   parameter int TIMEOUT = 40
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);
   localparam int W = $clog2(TIMEOUT);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (enable_i && cnt_q != LAST)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/multdiv_ctrl.sv
// X-stage sequencer for the shared multi-cycle mult/div unit.
// Optional perf counters behind MULTDIV_PERF_EN.
module multdiv_ctrl
   import multdiv_pkg::*;
#(
   parameter int REG_W   = 5,
   parameter int TIMEOUT = 40
`ifdef MULTDIV_PERF_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic          clock,
   input  logic          reset_n,
   multdiv_ctrl_if.slave bus
);
   md_state_e        state_q, state_d;
   md_op_e           op_q, op_d;
   logic [REG_W-1:0] rd_q, rd_d;
   logic             err_q, err_d;
   logic [2:0]       code_q, code_d;
   logic             start_q, start_d;
   logic             issue, accept, expired, stall_w;

   assign issue  = bus.issue_mult | bus.issue_div;
   assign accept = (state_q == IDLE) && issue;

   md_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear_i   (state_q != BUSY),
      .enable_i  (state_q == BUSY),
      .expired_o (expired)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rd_d    = rd_q;
      err_d   = err_q;
      code_d  = code_q;
      start_d = 1'b0;
      unique case (state_q)
         IDLE: if (issue) begin
            state_d = BUSY;
            op_d    = bus.issue_mult ? OP_MULT : OP_DIV;
            rd_d    = bus.issue_rd;
            err_d   = 1'b0;
            code_d  = 3'd0;
            start_d = 1'b1;
         end
         // a result on the expiry edge still beats the timeout
         BUSY: if (bus.md_ready) begin
            state_d = DONE;
            err_d   = bus.md_exception;
            code_d  = bus.md_exception ? err_code(op_q) : 3'd0;
         end else if (expired) begin
            state_d = DONE;
            err_d   = 1'b1;
            code_d  = MD_ERR_TIMEOUT;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         op_q    <= OP_MULT;
         rd_q    <= '0;
         err_q   <= 1'b0;
         code_q  <= 3'd0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
         code_q  <= code_d;
         start_q <= start_d;
      end
   end

   // idle stall is combinational so the issuing instr holds in X
   assign stall_w = (state_q == BUSY) || (accept && reset_n);

   always_comb begin
      bus.md_start_mult = start_q && (op_q == OP_MULT);
      bus.md_start_div  = start_q && (op_q == OP_DIV);
      bus.stall         = stall_w;
      bus.wb_valid      = 1'b0;
      bus.wb_rd         = '0;
      bus.wb_sel_status = 1'b0;
      bus.wb_code       = 3'd0;
      if (state_q == DONE) begin
         bus.wb_valid      = err_q || (rd_q != '0);
         bus.wb_rd         = err_q ? REG_W'(RSTATUS_REG) : rd_q;
         bus.wb_sel_status = err_q;
         bus.wb_code       = code_q;
      end
   end

`ifdef MULTDIV_PERF_EN
   logic [CNT_W-1:0] ops_q, busy_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ops_q  <= '0;
         busy_q <= '0;
      end else begin
         ops_q  <= ops_q + CNT_W'(accept);
         busy_q <= busy_q + CNT_W'(stall_w);
      end
   end

   assign bus.perf_ops  = ops_q;
   assign bus.perf_busy = busy_q;
`endif

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed vector bench for multdiv_ctrl.
module tb_multdiv_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   multdiv_ctrl_if bus ();

   multdiv_ctrl dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int ops_exp  = 0;
   int busy_exp = 0;

   // {start_mult, start_div, stall, wb_valid, wb_rd[4:0], sel, code[2:0]}
   typedef struct {
      logic        im;
      logic        id;
      logic [4:0]  rd;
      logic        rdy;
      logic        exc;
      logic [12:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [12:0] o(logic sm, logic sd, logic st,
                                     logic wb, logic [4:0] rd,
                                     logic sel, logic [2:0] code);
      return {sm, sd, st, wb, rd, sel, code};
   endfunction

   function automatic logic [12:0] outs();
      return {bus.md_start_mult, bus.md_start_div, bus.stall,
              bus.wb_valid, bus.wb_rd, bus.wb_sel_status, bus.wb_code};
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(logic im, logic id, logic [4:0] rd,
                        logic rdy, logic exc);
      bus.issue_mult   = im;
      bus.issue_div    = id;
      bus.issue_rd     = rd;
      bus.md_ready     = rdy;
      bus.md_exception = exc;
   endtask

   // one clock cycle: inputs after posedge, check at negedge
   task automatic cyc(logic im, logic id, logic [4:0] rd,
                      logic rdy, logic exc,
                      logic [12:0] exp, string nm);
      drive(im, id, rd, rdy, exc);
      @(negedge clk);
      chk(nm, 32'(outs()), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   task automatic add(logic im, logic id, logic [4:0] rd,
                      logic rdy, logic exc,
                      logic [12:0] exp, string nm);
      vec_t v;
      v.im = im; v.id = id; v.rd = rd;
      v.rdy = rdy; v.exc = exc;
      v.exp = exp; v.name = nm;
      vecs.push_back(v);
   endtask

   logic [12:0] z;

   initial begin
      z = '0;
      // mult rd=7, ready 3 cycles after issue
      add(1, 0, 7, 0, 0, o(0,0,1,0,0,0,0), "m_issue");
      add(1, 0, 7, 0, 0, o(1,0,1,0,0,0,0), "m_start");
      add(1, 0, 7, 0, 0, o(0,0,1,0,0,0,0), "m_busy");
      add(1, 0, 7, 1, 0, o(0,0,1,0,0,0,0), "m_ready");
      add(1, 0, 7, 0, 0, o(0,0,0,1,7,0,0), "m_wb");
      add(0, 0, 0, 0, 0, z,                "m_idle");
      // div with exception
      add(0, 1, 9, 0, 0, o(0,0,1,0,0,0,0), "d_issue");
      add(0, 1, 9, 0, 0, o(0,1,1,0,0,0,0), "d_start");
      add(0, 1, 9, 1, 1, o(0,0,1,0,0,0,0), "d_ready");
      add(0, 1, 9, 0, 0, o(0,0,0,1,30,1,5), "d_wb");
      // both issues at M+2; held through DONE
      add(1, 1, 3, 0, 0, o(0,0,1,0,0,0,0), "b_issue");
      add(1, 1, 3, 1, 0, o(1,0,1,0,0,0,0), "b_start");
      add(1, 1, 3, 0, 0, o(0,0,0,1,3,0,0), "b_wb");
      add(0, 0, 0, 1, 1, z,                "stray_rdy");
      add(0, 0, 0, 0, 0, z,                "idle2");
      // mult exception
      add(1, 0, 12, 0, 0, o(0,0,1,0,0,0,0), "me_issue");
      add(1, 0, 12, 1, 1, o(1,0,1,0,0,0,0), "me_start");
      add(0, 0, 0,  0, 0, o(0,0,0,1,30,1,4), "me_wb");
      add(0, 0, 0,  0, 0, z,                 "idle3");
      // rd=0 no error: suppressed
      add(1, 0, 0, 0, 0, o(0,0,1,0,0,0,0), "z_issue");
      add(1, 0, 0, 1, 0, o(1,0,1,0,0,0,0), "z_start");
      add(0, 0, 0, 0, 0, z,                "z_wb");
      // rd=0 with error: still reported
      add(0, 1, 0, 0, 0, o(0,0,1,0,0,0,0), "ze_issue");
      add(0, 1, 0, 1, 1, o(0,1,1,0,0,0,0), "ze_start");
      add(0, 0, 0, 0, 0, o(0,0,0,1,30,1,5), "ze_wb");
      add(0, 0, 0, 0, 0, z,                 "idle5");

      drive(0, 0, 0, 0, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("reset_outs", 32'(outs()), 32'(z));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         cyc(vecs[i].im, vecs[i].id, vecs[i].rd,
             vecs[i].rdy, vecs[i].exc, vecs[i].exp, vecs[i].name);
         busy_exp += int'(vecs[i].exp[10]);
         ops_exp  += int'(vecs[i].exp[12] | vecs[i].exp[11]);
      end

`ifdef MULTDIV_PERF_EN
      chk("perf_ops", 32'(bus.perf_ops), 32'(ops_exp));
      chk("perf_busy", 32'(bus.perf_busy), 32'(busy_exp));
`endif

      // watchdog: 40 busy cycles then timeout write-back
      cyc(1, 0, 5, 0, 0, o(0,0,1,0,0,0,0), "t_issue");
      for (int k = 0; k < 40; k++)
         cyc(1, 0, 5, 0, 0, o(k == 0,0,1,0,0,0,0), "t_busy");
      cyc(1, 0, 5, 0, 0, o(0,0,0,1,30,1,6), "t_wb");
      cyc(0, 0, 0, 0, 0, z, "t_idle");

      // ready on the expiry edge beats the timeout
      cyc(0, 1, 6, 0, 0, o(0,0,1,0,0,0,0), "l_issue");
      for (int k = 0; k < 39; k++)
         cyc(0, 1, 6, 0, 0, o(0,k == 0,1,0,0,0,0), "l_busy");
      cyc(0, 1, 6, 1, 0, o(0,0,1,0,0,0,0), "l_ready");
      cyc(0, 1, 6, 0, 0, o(0,0,0,1,6,0,0), "l_wb");
      cyc(0, 0, 0, 0, 0, z, "l_idle");

      // async reset mid-BUSY
      cyc(0, 1, 4, 0, 0, o(0,0,1,0,0,0,0), "r_issue");
      cyc(0, 1, 4, 0, 0, o(0,1,1,0,0,0,0), "r_start");
      drive(0, 1, 4, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("r_async", 32'(outs()), 32'(z));
      drive(0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(0, 0, 0, 1, 0, z, "r_rdy_ign");
      cyc(0, 0, 0, 0, 0, z, "r_quiet");
      cyc(1, 0, 11, 0, 0, o(0,0,1,0,0,0,0), "r2_issue");
      cyc(1, 0, 11, 1, 0, o(1,0,1,0,0,0,0), "r2_start");
      cyc(0, 0, 0,  0, 0, o(0,0,0,1,11,0,0), "r2_wb");
      cyc(0, 0, 0,  0, 0, z, "r2_idle");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
